// File: rtl/eth_rx_fsm_if.sv
// Receive-buffer write bus between the RX frame engine (master) and the buffer memory (slave).
interface eth_rx_fsm_if #(
  parameter int unsigned ADDR_W = 11
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/eth_rx_fsm.sv
// RGMII receive frame engine: preamble/SFD detect, MAC capture, inline CRC-32, FCS-stripped buffer writes.
// Optional define ETH_RX_MAC_FILTER_EN keeps only broadcast or MAC_ADDR destinations.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// S_IDLE      | waiting for the first 0x55 of a preamble
// S_PREAMBLE  | inside preamble, waiting for SFD 0xD5
// S_MAC_DST   | shifting in 6 destination MAC bytes
// S_MAC_SRC   | shifting in 6 source MAC bytes
// S_PAYLOAD   | length/type + payload through the 4-byte FCS delay line
// S_CHECK     | frame ended, latch status, pulse done on exit
// S_DROP      | discarding the rest of the frame until dv falls
module eth_rx_fsm #(
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned MAX_BYTES = 1502,
  parameter int unsigned MIN_BYTES = 48,
  parameter logic [47:0] MAC_ADDR  = 48'h1A_2B_3C_4D_5E_6F
) (
  input  logic              i_eth_clk,
  input  logic              i_rst_n,
  input  logic              i_rx_dv,
  input  logic              i_rx_er,
  input  logic [7:0]        i_rx_data_8b,
  input  logic              i_rx_release,
  eth_rx_fsm_if.master      o_mem,
  output logic [47:0]       o_mac_dst,
  output logic [47:0]       o_mac_src,
  output logic [ADDR_W-1:0] o_rx_size,
  output logic              o_rx_done,
  output logic              o_rx_good,
  output logic              o_rx_pending,
  output logic              o_busy,
  output logic [7:0]        o_drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_MAC_DST  = 3'd2,
    S_MAC_SRC  = 3'd3,
    S_PAYLOAD  = 3'd4,
    S_CHECK    = 3'd5,
    S_DROP     = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] LP_MAX      = ADDR_W'(MAX_BYTES);
  localparam logic [ADDR_W-1:0] LP_MIN      = ADDR_W'(MIN_BYTES);
  localparam logic [31:0]       LP_CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0]       LP_CRC_RES  = 32'hDEBB_20E3;
  localparam logic [7:0]        LP_PRE      = 8'h55;
  localparam logic [7:0]        LP_SFD      = 8'hD5;

  state_t            r_state;
  state_t            w_next;
  logic              w_drop_inc;

  logic [2:0]        r_byte_cnt;
  logic [31:0]       r_crc;
  logic [47:0]       r_dst_sh;
  logic [47:0]       r_src_sh;
  logic [7:0]        r_dly [4];
  logic [2:0]        r_dly_fill;
  logic [ADDR_W-1:0] r_wr_cnt;
  logic              r_err;

  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic [47:0]       r_mac_dst;
  logic [47:0]       r_mac_src;
  logic [ADDR_W-1:0] r_rx_size;
  logic              r_rx_done;
  logic              r_rx_good;
  logic              r_rx_pending;
  logic [7:0]        r_drop_cnt;

  logic [47:0]       w_dst_next;
  logic              w_filter_ok;
  logic              w_pending_eff;
  logic              w_sfd;
  logic              w_start;
  logic              w_crc_feed;
  logic              w_mac_byte;
  logic              w_pay_byte;
  logic              w_disp;
  logic              w_ovf;
  logic              w_wr;
  logic              w_crc_ok;
  logic              w_runt;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  assign w_dst_next = {r_dst_sh[39:0], i_rx_data_8b};

`ifdef ETH_RX_MAC_FILTER_EN
  assign w_filter_ok = (w_dst_next == 48'hFFFF_FFFF_FFFF) || (w_dst_next == MAC_ADDR);
`else
  // promiscuous: every destination is accepted
  assign w_filter_ok = (w_dst_next == MAC_ADDR) || 1'b1;
`endif

  // a release sampled together with a new preamble frees the buffer for that frame
  assign w_pending_eff = r_rx_pending && !i_rx_release;
  assign w_crc_ok      = (r_crc == LP_CRC_RES);
  assign w_runt        = (r_wr_cnt < LP_MIN);

  always_ff @(posedge i_eth_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_drop_inc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_rx_dv) begin
          if ((i_rx_data_8b == LP_PRE) && !w_pending_eff) begin
            w_next = S_PREAMBLE;
          end else begin
            w_next     = S_DROP;
            w_drop_inc = 1'b1;
          end
        end
      end
      S_PREAMBLE: begin
        if (!i_rx_dv) begin
          w_next = S_IDLE;
        end else if (i_rx_data_8b == LP_SFD) begin
          w_next = S_MAC_DST;
        end else if (i_rx_data_8b != LP_PRE) begin
          w_next     = S_DROP;
          w_drop_inc = 1'b1;
        end
      end
      S_MAC_DST: begin
        if (!i_rx_dv) begin
          w_next     = S_IDLE;
          w_drop_inc = 1'b1;
        end else if (r_byte_cnt == 3'd5) begin
          if (w_filter_ok) begin
            w_next = S_MAC_SRC;
          end else begin
            w_next     = S_DROP;
            w_drop_inc = 1'b1;
          end
        end
      end
      S_MAC_SRC: begin
        if (!i_rx_dv) begin
          w_next     = S_IDLE;
          w_drop_inc = 1'b1;
        end else if (r_byte_cnt == 3'd5) begin
          w_next = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (!i_rx_dv) begin
          w_next = S_CHECK;
        end else if (w_ovf) begin
          w_next     = S_DROP;
          w_drop_inc = 1'b1;
        end
      end
      S_CHECK: w_next = S_IDLE;
      S_DROP: begin
        if (!i_rx_dv) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy     = (r_state != S_IDLE);
    w_sfd      = (r_state == S_PREAMBLE) && i_rx_dv && (i_rx_data_8b == LP_SFD);
    w_start    = (r_state == S_IDLE) && (w_next == S_PREAMBLE);
    w_mac_byte = ((r_state == S_MAC_DST) || (r_state == S_MAC_SRC)) && i_rx_dv;
    w_pay_byte = (r_state == S_PAYLOAD) && i_rx_dv;
    w_crc_feed = w_mac_byte || w_pay_byte;
    // only a byte pushed out of the full delay line is written, so the FCS never is
    w_disp     = w_pay_byte && (r_dly_fill == 3'd4);
    w_ovf      = w_disp && (r_wr_cnt == LP_MAX);
    w_wr       = w_disp && !w_ovf;
  end

  always_ff @(posedge i_eth_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_byte_cnt <= 3'd0;
      r_crc      <= LP_CRC_INIT;
      r_dst_sh   <= 48'd0;
      r_src_sh   <= 48'd0;
      r_dly_fill <= 3'd0;
      r_wr_cnt   <= '0;
      r_err      <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_dly[i] <= 8'd0;
      end
    end else begin
      if (w_sfd) begin
        r_crc <= LP_CRC_INIT;
      end else if (w_crc_feed) begin
        r_crc <= crc_byte(r_crc, i_rx_data_8b);
      end

      if (w_sfd) begin
        r_byte_cnt <= 3'd0;
      end else if (w_mac_byte) begin
        r_byte_cnt <= (r_byte_cnt == 3'd5) ? 3'd0 : r_byte_cnt + 3'd1;
      end

      if ((r_state == S_MAC_DST) && i_rx_dv) begin
        r_dst_sh <= w_dst_next;
      end
      if ((r_state == S_MAC_SRC) && i_rx_dv) begin
        r_src_sh <= {r_src_sh[39:0], i_rx_data_8b};
      end

      if (w_sfd) begin
        r_dly_fill <= 3'd0;
      end else if (w_pay_byte && (r_dly_fill != 3'd4)) begin
        r_dly_fill <= r_dly_fill + 3'd1;
      end
      if (w_pay_byte) begin
        r_dly[0] <= i_rx_data_8b;
        for (int i = 1; i < 4; i++) begin
          r_dly[i] <= r_dly[i-1];
        end
      end

      if (w_sfd) begin
        r_wr_cnt <= '0;
      end else if (w_wr) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
      end

      if (w_start) begin
        r_err <= 1'b0;
      end else if ((r_state != S_IDLE) && i_rx_dv && i_rx_er) begin
        r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_eth_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= 8'd0;
      r_mac_dst    <= 48'd0;
      r_mac_src    <= 48'd0;
      r_rx_size    <= '0;
      r_rx_done    <= 1'b0;
      r_rx_good    <= 1'b0;
      r_rx_pending <= 1'b0;
      r_drop_cnt   <= 8'd0;
    end else begin
      r_wr_en <= w_wr;
      if (w_wr) begin
        r_wr_addr <= r_wr_cnt;
        r_wr_data <= r_dly[3];
      end

      r_rx_done <= (r_state == S_CHECK);
      if (r_state == S_CHECK) begin
        r_rx_good <= w_crc_ok && !r_err && !w_runt;
        r_rx_size <= r_wr_cnt;
        r_mac_dst <= r_dst_sh;
        r_mac_src <= r_src_sh;
      end

      if (r_state == S_CHECK) begin
        r_rx_pending <= 1'b1;
      end else if (i_rx_release) begin
        r_rx_pending <= 1'b0;
      end

      if (w_drop_inc && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  assign o_mem.wr_en   = r_wr_en;
  assign o_mem.wr_addr = r_wr_addr;
  assign o_mem.wr_data = r_wr_data;
  assign o_mac_dst     = r_mac_dst;
  assign o_mac_src     = r_mac_src;
  assign o_rx_size     = r_rx_size;
  assign o_rx_done     = r_rx_done;
  assign o_rx_good     = r_rx_good;
  assign o_rx_pending  = r_rx_pending;
  assign o_drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_eth_rx_fsm.sv
// Scoreboard bench for eth_rx_fsm: expected writes and completions are queued as frames are driven.
module tb_eth_rx_fsm;
  localparam int ADDR_W = 11;
  localparam int GAP    = 16;
  localparam logic [47:0] SRC_MAC = 48'h1A_2B_3C_4D_5E_6F;
  localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              rx_dv = 1'b0;
  logic              rx_er = 1'b0;
  logic [7:0]        rx_data = 8'd0;
  logic              rx_release = 1'b0;
  logic [47:0]       mac_dst;
  logic [47:0]       mac_src;
  logic [ADDR_W-1:0] rx_size;
  logic              rx_done;
  logic              rx_good;
  logic              rx_pending;
  logic              busy;
  logic [7:0]        drop_cnt;

  eth_rx_fsm_if #(.ADDR_W(ADDR_W)) mem_if ();

  eth_rx_fsm #(.ADDR_W(ADDR_W)) dut (
    .i_eth_clk    (clk),
    .i_rst_n      (rst_n),
    .i_rx_dv      (rx_dv),
    .i_rx_er      (rx_er),
    .i_rx_data_8b (rx_data),
    .i_rx_release (rx_release),
    .o_mem        (mem_if),
    .o_mac_dst    (mac_dst),
    .o_mac_src    (mac_src),
    .o_rx_size    (rx_size),
    .o_rx_done    (rx_done),
    .o_rx_good    (rx_good),
    .o_rx_pending (rx_pending),
    .o_busy       (busy),
    .o_drop_cnt   (drop_cnt)
  );

  always #4 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  typedef struct packed {
    logic [ADDR_W-1:0] size;
    logic              good;
    logic [47:0]       dst;
    logic [47:0]       src;
  } done_t;

  wr_t        q_wr[$];
  done_t      q_done[$];
  logic [7:0] tx[$];
  logic [7:0] mem [0:2047];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int t_dv0 = 0;
  int n_done = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  task automatic make_frame(input logic [47:0] dst, input logic [47:0] src, input int plen,
                            input bit corrupt);
    logic [7:0]  body[$];
    logic [31:0] c;
    tx.delete();
    repeat (7) tx.push_back(8'h55);
    tx.push_back(8'hD5);
    for (int i = 0; i < 6; i++) body.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) body.push_back(src[47-8*i -: 8]);
    body.push_back(8'h08);
    body.push_back(8'h00);
    for (int i = 0; i < plen; i++) body.push_back(8'(i));
    c = 32'hFFFF_FFFF;
    foreach (body[i]) c = crc_upd(c, body[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) body.push_back(c[8*i +: 8]);
    if (corrupt) body[body.size()-1] = body[body.size()-1] ^ 8'h01;
    foreach (body[i]) tx.push_back(body[i]);
  endtask

  // length/type + payload start at byte 20; anything past 1502 written bytes overflows
  task automatic expect_frame(input logic [47:0] dst, input logic [47:0] src, input bit good);
    int    n;
    wr_t   w;
    done_t d;
    n = tx.size() - 24;
    for (int i = 0; i < n && i < 1502; i++) begin
      w.addr = ADDR_W'(i);
      w.data = tx[20+i];
      q_wr.push_back(w);
    end
    if (n <= 1502) begin
      d.size = ADDR_W'(n);
      d.good = good && (n >= 48);
      d.dst  = dst;
      d.src  = src;
      q_done.push_back(d);
    end
  endtask

  task automatic send(input int n_bytes, input int er_at, input bit rel_first);
    for (int i = 0; i < n_bytes; i++) begin
      @(negedge clk);
      rx_dv      = 1'b1;
      rx_data    = tx[i];
      rx_er      = (i == er_at);
      rx_release = rel_first && (i == 0);
    end
    @(negedge clk);
    rx_dv      = 1'b0;
    rx_er      = 1'b0;
    rx_release = 1'b0;
    rx_data    = 8'd0;
    t_dv0      = cyc;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic after_frame(input string tag, input int exp_done, input int exp_drop);
    check_eq({tag, "_done_cnt"}, 64'(n_done), 64'(exp_done));
    check_eq({tag, "_wr_left"}, 64'(q_wr.size()), 64'd0);
    check_eq({tag, "_done_left"}, 64'(q_done.size()), 64'd0);
    check_eq({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(exp_drop));
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic release_buf();
    @(negedge clk);
    rx_release = 1'b1;
    @(negedge clk);
    rx_release = 1'b0;
    check_eq("pending_cleared", 64'(rx_pending), 64'd0);
  endtask

  initial begin
    wr_t   w;
    done_t d;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (mem_if.wr_en) begin
        mem[mem_if.wr_addr] = mem_if.wr_data;
        check_eq("wr_expected", 64'(q_wr.size() != 0), 64'd1);
        if (q_wr.size() != 0) begin
          w = q_wr.pop_front();
          check_eq("wr_addr", 64'(mem_if.wr_addr), 64'(w.addr));
          check_eq("wr_data", 64'(mem_if.wr_data), 64'(w.data));
        end
      end
      if (rx_done) begin
        n_done++;
        check_eq("done_latency", 64'(cyc - t_dv0), 64'd2);
        check_eq("done_expected", 64'(q_done.size() != 0), 64'd1);
        if (q_done.size() != 0) begin
          d = q_done.pop_front();
          check_eq("rx_size", 64'(rx_size), 64'(d.size));
          check_eq("rx_good", 64'(rx_good), 64'(d.good));
          check_eq("mac_dst", 64'(mac_dst), 64'(d.dst));
          check_eq("mac_src", 64'(mac_src), 64'(d.src));
          check_eq("pending_at_done", 64'(rx_pending), 64'd1);
        end
      end
    end
  end

  initial begin
    #(8 * 40000);
    $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_pending", 64'(rx_pending), 64'd0);
    check_eq("rst_done", 64'(rx_done), 64'd0);
    check_eq("rst_good", 64'(rx_good), 64'd0);
    check_eq("rst_size", 64'(rx_size), 64'd0);
    check_eq("rst_drop", 64'(drop_cnt), 64'd0);
    check_eq("rst_wr_en", 64'(mem_if.wr_en), 64'd0);
    check_eq("rst_mac_dst", 64'(mac_dst), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // basic broadcast frame
    make_frame(BCAST, SRC_MAC, 46, 1'b0);
    expect_frame(BCAST, SRC_MAC, 1'b1);
    send(tx.size(), -1, 1'b0);
    after_frame("basic", 1, 0);
    check_eq("mem0", 64'(mem[0]), 64'h08);
    check_eq("mem1", 64'(mem[1]), 64'h00);
    check_eq("mem47", 64'(mem[47]), 64'h2D);
    check_eq("basic_size", 64'(rx_size), 64'd48);
    check_eq("basic_good", 64'(rx_good), 64'd1);
    check_eq("basic_pending", 64'(rx_pending), 64'd1);
    release_buf();

    make_frame(BCAST, SRC_MAC, 46, 1'b1);
    expect_frame(BCAST, SRC_MAC, 1'b0);
    send(tx.size(), -1, 1'b0);
    after_frame("bad_fcs", 2, 0);

    // still pending: whole frame dropped
    make_frame(BCAST, SRC_MAC, 46, 1'b0);
    send(tx.size(), -1, 1'b0);
    after_frame("pend_drop", 2, 1);
    check_eq("pend_drop_pending", 64'(rx_pending), 64'd1);

    // release in the same cycle as the first preamble byte
    make_frame(BCAST, SRC_MAC, 46, 1'b0);
    expect_frame(BCAST, SRC_MAC, 1'b1);
    send(tx.size(), -1, 1'b1);
    after_frame("rel_start", 3, 1);
    release_buf();

    make_frame(BCAST, SRC_MAC, 46, 1'b0);
    expect_frame(BCAST, SRC_MAC, 1'b0);
    send(tx.size(), 30, 1'b0);
    after_frame("rx_er", 4, 1);
    release_buf();

    make_frame(BCAST, SRC_MAC, 40, 1'b0);
    expect_frame(BCAST, SRC_MAC, 1'b0);
    send(tx.size(), -1, 1'b0);
    after_frame("runt", 5, 1);
    check_eq("runt_size", 64'(rx_size), 64'd42);
    release_buf();

    make_frame(48'h0A0B_0C0D_0E0F, SRC_MAC, 46, 1'b0);
    send(11, -1, 1'b0);
    after_frame("trunc", 5, 2);
    check_eq("trunc_mac_hold", 64'(mac_dst), 64'(BCAST));

    tx.delete();
    tx.push_back(8'h42);
    repeat (4) tx.push_back(8'h55);
    send(tx.size(), -1, 1'b0);
    after_frame("garbage", 5, 3);

    tx.delete();
    repeat (3) tx.push_back(8'h55);
    send(tx.size(), -1, 1'b0);
    after_frame("short_pre", 5, 3);

    make_frame(BCAST, SRC_MAC, 1598, 1'b0);
    expect_frame(BCAST, SRC_MAC, 1'b1);
    send(tx.size(), -1, 1'b0);
    after_frame("overflow", 5, 4);
    check_eq("ovf_mem1501", 64'(mem[1501]), 64'(tx[20+1501]));

    // reset while in the source MAC field
    make_frame(BCAST, SRC_MAC, 46, 1'b0);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      rx_dv   = 1'b1;
      rx_data = tx[i];
    end
    @(negedge clk);
    rst_n = 1'b0;
    rx_dv = 1'b0;
    #1;
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_drop", 64'(drop_cnt), 64'd0);
    check_eq("midrst_mac_dst", 64'(mac_dst), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    make_frame(BCAST, SRC_MAC, 46, 1'b0);
    expect_frame(BCAST, SRC_MAC, 1'b1);
    send(tx.size(), -1, 1'b0);
    after_frame("post_rst", 6, 0);
    release_buf();

`ifdef ETH_RX_MAC_FILTER_EN
    make_frame(48'h0200_0000_0001, SRC_MAC, 46, 1'b0);
    send(tx.size(), -1, 1'b0);
    after_frame("filt_reject", 6, 1);
    release_buf();
    make_frame(SRC_MAC, BCAST, 46, 1'b0);
    expect_frame(SRC_MAC, BCAST, 1'b1);
    send(tx.size(), -1, 1'b0);
    after_frame("filt_accept", 7, 1);
`else
    make_frame(48'h0200_0000_0001, SRC_MAC, 46, 1'b0);
    expect_frame(48'h0200_0000_0001, SRC_MAC, 1'b1);
    send(tx.size(), -1, 1'b0);
    after_frame("promisc", 7, 0);
    release_buf();
    make_frame(SRC_MAC, BCAST, 46, 1'b0);
    expect_frame(SRC_MAC, BCAST, 1'b1);
    send(tx.size(), -1, 1'b0);
    after_frame("own_mac", 8, 0);
`endif
    release_buf();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
